vga_timing_gen: RTL

- Parametrised VGA raster timing generator. It is the next-generation replacement for the fixed 640x480 sync logic that drives hSync/vSync and the VGA_R/G/B pixel pipeline in the Wrapper top level.
- Outputs sync pulses, pixel coordinates, an active-video flag, and per-pixel, per-line and per-frame strobes.
- A frame counter is provided for game-tick and animation timing.
- An enable input pauses the raster. Resolution, porches, sync polarity and the clock-to-pixel divide are all set by parameters.

---
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator.
//
// Stage 0 holds the raster counters. A clock divider produces one pixel
// advance every CLK_DIV clocks while enable is high. Stage 1 registers every
// output from the stage-0 decode, so all outputs lag the counters by one clock.
//
// Ports
//   clk          in   system clock (single domain)
//   reset        in   synchronous, active-high reset
//   enable       in   1 = raster advances, 0 = raster holds
//   hSync        out  horizontal sync, asserted level HSYNC_POL
//   vSync        out  vertical sync, asserted level VSYNC_POL
//   active       out  1 while the displayed pixel is in the visible area
//   x            out  horizontal counter, 0..H_TOTAL-1 (includes blanking)
//   y            out  vertical counter, 0..V_TOTAL-1 (includes blanking)
//   pixel_tick   out  strobe on the last clock a given x/y is shown
//   line_start   out  strobe on the first clock of a new line
//   frame_start  out  strobe on the first clock of a new frame
//   frame_count  out  number of completed frames, modulo 2**FRAME_W
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int FRAME_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               hSync,
    output logic               vSync,
    output logic               active,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               pixel_tick,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);

    // Sync window test: asserted while lo <= c < hi.
    function automatic logic in_window(input int c, input int lo, input int hi);
        return (c >= lo) && (c < hi);
    endfunction

    // ---- stage 0: raster counters -------------------------------------------
    logic [DIV_W-1:0] div_cnt_p0;
    logic [X_W-1:0]   h_cnt_p0;
    logic [Y_W-1:0]   v_cnt_p0;
    logic             vld_p0;
    logic             h_last_p0;
    logic             v_last_p0;
    // One-clock flags marking the first clock the counters sit at a freshly
    // wrapped position; they become the strobes a clock later, so a strobe
    // can fire only once per wrap no matter how enable toggles afterwards.
    logic             line_flag_p0;
    logic             frame_flag_p0;
    // High for the first clock after reset release, to announce the restart.
    logic             start_pend_p0;

    assign vld_p0    = enable && (div_cnt_p0 == DIV_LAST);
    assign h_last_p0 = (h_cnt_p0 == H_LAST);
    assign v_last_p0 = (v_cnt_p0 == V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_p0    <= '0;
            h_cnt_p0      <= '0;
            v_cnt_p0      <= '0;
            line_flag_p0  <= 1'b0;
            frame_flag_p0 <= 1'b0;
            start_pend_p0 <= 1'b1;
        end else begin
            start_pend_p0 <= 1'b0;
            line_flag_p0  <= vld_p0 && h_last_p0;
            frame_flag_p0 <= vld_p0 && h_last_p0 && v_last_p0;
            if (enable) begin
                div_cnt_p0 <= (div_cnt_p0 == DIV_LAST) ? '0 : div_cnt_p0 + 1'b1;
            end
            if (vld_p0) begin
                if (h_last_p0) begin
                    h_cnt_p0 <= '0;
                    v_cnt_p0 <= v_last_p0 ? '0 : v_cnt_p0 + 1'b1;
                end else begin
                    h_cnt_p0 <= h_cnt_p0 + 1'b1;
                end
            end
        end
    end

    // ---- stage 1: registered outputs ----------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            hSync       <= ~HSYNC_POL;
            vSync       <= ~VSYNC_POL;
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            x           <= h_cnt_p0;
            y           <= v_cnt_p0;
            active      <= (int'(h_cnt_p0) < H_ACTIVE) && (int'(v_cnt_p0) < V_ACTIVE);
            hSync       <= in_window(int'(h_cnt_p0), H_ACTIVE + H_FRONT,
                                     H_ACTIVE + H_FRONT + H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            vSync       <= in_window(int'(v_cnt_p0), V_ACTIVE + V_FRONT,
                                     V_ACTIVE + V_FRONT + V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            pixel_tick  <= vld_p0;
            line_start  <= line_flag_p0 || start_pend_p0;
            frame_start <= frame_flag_p0 || start_pend_p0;
            // Only wrap-caused frame starts count a completed frame.
            if (frame_flag_p0) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule
